stereo_sample_mixer: RTL and testbench



---
 rtl/stereo_sample_mixer_pkg.sv | 14 +
 rtl/stereo_sample_mixer_sat_shift.sv | 32 +++
 rtl/stereo_sample_mixer.sv | 121 ++++++++++++
 tb/tb_stereo_sample_mixer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_sample_mixer_pkg.sv
// Shared constants and types for the stereo sample mixer.
package stereo_sample_mixer_pkg;

  localparam int DAC_OUTPUT_WIDTH = 16;
  localparam int MIX_NUM_CHANNELS = 18;
  localparam int MIX_IN_WIDTH     = 16;
  localparam int MIX_GAIN_SHIFT   = 0;

  // Wide enough to sum NUM_CHANNELS sign-extended inputs without overflow.
  localparam int MIX_ACC_W = MIX_IN_WIDTH + $clog2(MIX_NUM_CHANNELS) + 1;

  typedef logic signed [MIX_ACC_W-1:0] mix_acc_t;

endpackage

// File: rtl/stereo_sample_mixer_sat_shift.sv
// Arithmetic right shift followed by a signed clamp to OUT_W bits.
module stereo_sample_mixer_sat_shift #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  assign shifted = $signed(din) >>> SHIFT;

  // Clamp to the output range and flag when the value had to be limited.
  always_comb begin
    dout = shifted[OUT_W-1:0];
    clip = 1'b0;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/stereo_sample_mixer.sv
// Accumulates time-multiplexed per-channel stereo samples over one sample
// period, then scales, saturates and registers the mix for the i2s block.
module stereo_sample_mixer
  import stereo_sample_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = MIX_NUM_CHANNELS,
  parameter int IN_WIDTH     = MIX_IN_WIDTH,
  parameter int OUT_WIDTH    = DAC_OUTPUT_WIDTH,
  parameter int GAIN_SHIFT   = MIX_GAIN_SHIFT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_clk_en,
  input  logic                 channel_valid,
  input  logic [IN_WIDTH-1:0]  channel_l,
  input  logic [IN_WIDTH-1:0]  channel_r,
  input  logic                 clear_status,
  output logic [OUT_WIDTH-1:0] left_channel,
  output logic [OUT_WIDTH-1:0] right_channel,
  output logic                 sample_valid,
  output logic                 clip_l,
  output logic                 clip_r,
  output logic                 count_err
);

  localparam int ACC_W = IN_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int CNT_W = $clog2(NUM_CHANNELS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CHANNELS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(NUM_CHANNELS + 1);

  logic signed [ACC_W-1:0] ext_l, ext_r;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] hold_l, hold_r;
  logic [CNT_W-1:0]        ch_cnt, hold_cnt;
  logic                    hold_valid;
  logic [OUT_WIDTH-1:0]    sat_l, sat_r;
  logic                    clip_now_l, clip_now_r;
  logic                    cnt_bad;

  assign ext_l   = {{(ACC_W-IN_WIDTH){channel_l[IN_WIDTH-1]}}, channel_l};
  assign ext_r   = {{(ACC_W-IN_WIDTH){channel_r[IN_WIDTH-1]}}, channel_r};
  assign cnt_bad = (hold_cnt != CNT_FULL);

  // Accumulate during the period; on sample_clk_en snapshot and restart with
  // the same-cycle sample so nothing is lost or counted twice.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_l      <= '0;
      acc_r      <= '0;
      ch_cnt     <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_cnt   <= '0;
      hold_valid <= 1'b0;
    end else if (sample_clk_en) begin
      hold_l     <= acc_l;
      hold_r     <= acc_r;
      hold_cnt   <= ch_cnt;
      hold_valid <= 1'b1;
      acc_l      <= channel_valid ? ext_l : '0;
      acc_r      <= channel_valid ? ext_r : '0;
      ch_cnt     <= {{(CNT_W-1){1'b0}}, channel_valid};
    end else begin
      hold_valid <= 1'b0;
      if (channel_valid) begin
        if (ch_cnt < CNT_FULL) begin
          acc_l <= acc_l + ext_l;
          acc_r <= acc_r + ext_r;
        end
        if (ch_cnt != CNT_OVER) begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

  stereo_sample_mixer_sat_shift #(
    .IN_W (ACC_W),
    .OUT_W(OUT_WIDTH),
    .SHIFT(GAIN_SHIFT)
  ) u_sat_l (
    .din (hold_l),
    .dout(sat_l),
    .clip(clip_now_l)
  );

  stereo_sample_mixer_sat_shift #(
    .IN_W (ACC_W),
    .OUT_W(OUT_WIDTH),
    .SHIFT(GAIN_SHIFT)
  ) u_sat_r (
    .din (hold_r),
    .dout(sat_r),
    .clip(clip_now_r)
  );

  // Register the scaled mix and pulse sample_valid; outputs hold until the
  // next close. Sticky flags: a set event beats clear_status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_channel  <= '0;
      right_channel <= '0;
      sample_valid  <= 1'b0;
      clip_l        <= 1'b0;
      clip_r        <= 1'b0;
      count_err     <= 1'b0;
    end else begin
      sample_valid <= hold_valid;
      if (hold_valid) begin
        left_channel  <= sat_l;
        right_channel <= sat_r;
      end
      clip_l    <= (hold_valid & clip_now_l) | (clip_l    & ~clear_status);
      clip_r    <= (hold_valid & clip_now_r) | (clip_r    & ~clear_status);
      count_err <= (hold_valid & cnt_bad)    | (count_err & ~clear_status);
    end
  end

endmodule

// File: tb/tb_stereo_sample_mixer.sv
// Self-checking bench: directed table, hand sequences and random stimulus,
// all compared every cycle against a queue-based behavioural model.
module tb_stereo_sample_mixer;

  localparam int NCH = 18;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_clk_en = 1'b0;
  logic        channel_valid = 1'b0;
  logic [15:0] channel_l = '0;
  logic [15:0] channel_r = '0;
  logic        clear_status = 1'b0;

  logic [15:0] left_channel [2];
  logic [15:0] right_channel [2];
  logic        sample_valid [2];
  logic        clip_l [2];
  logic        clip_r [2];
  logic        count_err [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stereo_sample_mixer #(.GAIN_SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
    .channel_valid(channel_valid), .channel_l(channel_l), .channel_r(channel_r),
    .clear_status(clear_status), .left_channel(left_channel[0]),
    .right_channel(right_channel[0]), .sample_valid(sample_valid[0]),
    .clip_l(clip_l[0]), .clip_r(clip_r[0]), .count_err(count_err[0])
  );

  stereo_sample_mixer #(.GAIN_SHIFT(2)) dut_g2 (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
    .channel_valid(channel_valid), .channel_l(channel_l), .channel_r(channel_r),
    .clear_status(clear_status), .left_channel(left_channel[1]),
    .right_channel(right_channel[1]), .sample_valid(sample_valid[1]),
    .clip_l(clip_l[1]), .clip_r(clip_r[1]), .count_err(count_err[1])
  );

  // ---------------- behavioural model ----------------
  int q_l[$];
  int q_r[$];
  bit pend;
  int pend_sum_l, pend_sum_r, pend_cnt;
  bit exp_sv;
  int exp_l [2];
  int exp_r [2];
  bit exp_cl [2];
  bit exp_cr [2];
  bit exp_ce [2];

  function automatic int sat(input int s, input int sh, output bit c);
    int v;
    v = s >>> sh;
    c = 1'b0;
    if (v > 32767) begin v = 32767; c = 1'b1; end
    else if (v < -32768) begin v = -32768; c = 1'b1; end
    return v;
  endfunction

  task automatic model_reset();
    q_l.delete();
    q_r.delete();
    pend = 1'b0;
    pend_sum_l = 0; pend_sum_r = 0; pend_cnt = 0;
    exp_sv = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_l[d] = 0; exp_r[d] = 0;
      exp_cl[d] = 0; exp_cr[d] = 0; exp_ce[d] = 0;
    end
  endtask

  // Effect of one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input bit v, input int l, input int r, input bit en, input bit clr);
    bit cl, cr, ce;
    int vl, vr;
    exp_sv = pend;
    for (int d = 0; d < 2; d++) begin
      cl = 0; cr = 0; ce = 0;
      if (pend) begin
        vl = sat(pend_sum_l, (d == 0) ? 0 : 2, cl);
        vr = sat(pend_sum_r, (d == 0) ? 0 : 2, cr);
        exp_l[d] = vl;
        exp_r[d] = vr;
        ce = (pend_cnt != NCH);
      end
      exp_cl[d] = (clr ? 1'b0 : exp_cl[d]) | cl;
      exp_cr[d] = (clr ? 1'b0 : exp_cr[d]) | cr;
      exp_ce[d] = (clr ? 1'b0 : exp_ce[d]) | ce;
    end
    if (en) begin
      pend = 1'b1;
      pend_sum_l = 0; pend_sum_r = 0;
      for (int i = 0; i < q_l.size() && i < NCH; i++) begin
        pend_sum_l += q_l[i];
        pend_sum_r += q_r[i];
      end
      pend_cnt = q_l.size();
      q_l.delete();
      q_r.delete();
    end else begin
      pend = 1'b0;
    end
    if (v) begin
      q_l.push_back(l);
      q_r.push_back(r);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d sample_valid", d), int'(sample_valid[d]), int'(exp_sv));
      check($sformatf("dut%0d left", d), int'($signed(left_channel[d])), exp_l[d]);
      check($sformatf("dut%0d right", d), int'($signed(right_channel[d])), exp_r[d]);
      check($sformatf("dut%0d clip_l", d), int'(clip_l[d]), int'(exp_cl[d]));
      check($sformatf("dut%0d clip_r", d), int'(clip_r[d]), int'(exp_cr[d]));
      check($sformatf("dut%0d count_err", d), int'(count_err[d]), int'(exp_ce[d]));
    end
  endtask

  // One clock: drive inputs, take the edge, update model, compare 1 ns later.
  task automatic step(input bit v, input int l, input int r, input bit en, input bit clr);
    channel_valid = v;
    channel_l     = 16'(l);
    channel_r     = 16'(r);
    sample_clk_en = en;
    clear_status  = clr;
    @(posedge clk);
    model_edge(v, l, r, en, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    channel_valid = 1'b0; sample_clk_en = 1'b0; clear_status = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int n;
    int l;
    int r;
    int exp_l;
    int exp_r;
    bit cl;
    bit cr;
    bit ce;
    int exp_l2;
    int exp_r2;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{18,   100,  -100,   1800,  -1800, 1'b0, 1'b0, 1'b0,   450,   -450};
    tbl[1] = '{18,  4000, -4000,  32767, -32768, 1'b1, 1'b1, 1'b0, 18000, -18000};
    tbl[2] = '{17,    10,   -10,    170,   -170, 1'b0, 1'b0, 1'b1,    42,    -43};
    tbl[3] = '{19,    10,    20,    180,    360, 1'b0, 1'b0, 1'b1,    45,     90};
    tbl[4] = '{18, -2000,  2000, -32768,  32767, 1'b1, 1'b1, 1'b0, -9000,   9000};

    model_reset();
    @(posedge clk);
    do_reset();
    idle(2);

    for (int t = 0; t < 5; t++) begin
      step(1'b0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < tbl[t].n; i++) step(1'b1, tbl[t].l, tbl[t].r, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      check("tbl sample_valid", int'(sample_valid[0]), 1);
      check("tbl left", int'($signed(left_channel[0])), tbl[t].exp_l);
      check("tbl right", int'($signed(right_channel[0])), tbl[t].exp_r);
      check("tbl clip_l", int'(clip_l[0]), int'(tbl[t].cl));
      check("tbl clip_r", int'(clip_r[0]), int'(tbl[t].cr));
      check("tbl count_err", int'(count_err[0]), int'(tbl[t].ce));
      check("tbl g2 left", int'($signed(left_channel[1])), tbl[t].exp_l2);
      check("tbl g2 right", int'($signed(right_channel[1])), tbl[t].exp_r2);
      check("tbl g2 clip_l", int'(clip_l[1]), 0);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      check("tbl pulse width", int'(sample_valid[0]), 0);
      check("tbl hold left", int'($signed(left_channel[0])), tbl[t].exp_l);
    end

    // clear_status drops sticky flags one cycle later
    step(1'b0, 0, 0, 1'b0, 1'b1);
    check("clear clip_l", int'(clip_l[0]), 0);
    check("clear clip_r", int'(clip_r[0]), 0);

    // sample coincident with sample_clk_en belongs to the next period
    for (int i = 0; i < NCH; i++) step(1'b1, 5, 0, 1'b0, 1'b0);
    step(1'b1, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < NCH - 1; i++) begin
      step(1'b1, 1, 0, 1'b0, 1'b0);
      if (i == 0) check("coincident first left", int'($signed(left_channel[0])), 90);
    end
    step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    check("coincident left", int'($signed(left_channel[0])), 24);
    check("coincident count_err", int'(count_err[0]), 0);

    // set flags, then reset mid-period
    for (int i = 0; i < NCH; i++) step(1'b1, 30000, -30000, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 9; i++) step(1'b1, 50, 50, 1'b0, 1'b0);
    do_reset();
    check("reset left", int'($signed(left_channel[0])), 0);
    check("reset clip_l", int'(clip_l[0]), 0);
    for (int i = 0; i < NCH; i++) step(1'b1, 3, 3, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    check("post reset left", int'($signed(left_channel[0])), 54);
    check("post reset count_err", int'(count_err[0]), 0);
    idle(2);

    // randomized traffic including back-to-back closes at minimum spacing
    begin
      int since;
      bit v, en, clr;
      int l, r;
      since = 0;
      for (int c = 0; c < 1500; c++) begin
        v   = ($urandom_range(0, 3) != 0);
        en  = (since >= 3) && (($urandom_range(0, 19) == 0) || since >= 24);
        clr = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 1) == 1) begin
          l = int'($urandom_range(0, 65535)) - 32768;
          r = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          l = int'($urandom_range(0, 400)) - 200;
          r = int'($urandom_range(0, 400)) - 200;
        end
        step(v, l, r, en, clr);
        since = en ? 0 : since + 1;
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
